// File: rtl/food_spawn_ctrl_pkg.sv
// Shared grid geometry, controller state encoding and cell helpers for food placement.
package food_spawn_ctrl_pkg;

    localparam int unsigned GRID_W    = 32;
    localparam int unsigned GRID_H    = 24;
    localparam int unsigned COL_BITS  = 5;
    localparam int unsigned ROW_BITS  = 5;
    localparam int unsigned NUM_CELLS = GRID_W * GRID_H;
    localparam int unsigned CNT_BITS  = $clog2(NUM_CELLS) + 1;

    typedef enum logic [3:0] {
        StIdle,
        StDrawX,
        StDrawY,
        StCheck,
        StWait,
        StReject,
        StScanRd,
        StScanWt,
        StDone,
        StFail
    } state_e;

    typedef struct packed {
        logic [COL_BITS-1:0] x;
        logic [ROW_BITS-1:0] y;
    } cell_t;

    // Row-major successor of a cell, wrapping from the last cell back to (0,0).
    function automatic cell_t next_cell(input cell_t c);
        cell_t n;
        if (32'(c.x) == GRID_W - 1) begin
            n.x = '0;
            n.y = (32'(c.y) == GRID_H - 1) ? '0 : c.y + 1'b1;
        end else begin
            n.x = c.x + 1'b1;
            n.y = c.y;
        end
        return n;
    endfunction

endpackage

// File: rtl/food_spawn_ctrl_grid_scan_ctr.sv
// Loadable row-major wrapping (x,y) counter used by the fallback scan, plus the count of
// cells read so far so the controller can tell when the whole board has been visited.
module food_spawn_ctrl_grid_scan_ctr
    import food_spawn_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_load,     // start scan at the cell after i_from
    input  cell_t i_from,
    input  logic  i_adv,      // step to the next cell
    input  logic  i_count,    // one occupancy read issued at o_pos
    output cell_t o_pos,
    output cell_t o_pos_next,
    output logic  o_all_scanned
);

    cell_t               r_pos;
    logic [CNT_BITS-1:0] r_scanned;

    // Scan position and read count; load restarts the count from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos     <= '0;
            r_scanned <= '0;
        end else begin
            if (i_load) begin
                r_pos     <= next_cell(i_from);
                r_scanned <= '0;
            end else begin
                if (i_adv) begin
                    r_pos <= next_cell(r_pos);
                end
                if (i_count) begin
                    r_scanned <= r_scanned + 1'b1;
                end
            end
        end
    end

    assign o_pos         = r_pos;
    assign o_pos_next    = next_cell(r_pos);
    assign o_all_scanned = (r_scanned == CNT_BITS'(NUM_CELLS));

endmodule

// File: rtl/food_spawn_ctrl.sv
// Food placement controller: random candidate draws from the LFSR, occupancy checks, and a
// deterministic row-major scan once the random attempts are exhausted.
module food_spawn_ctrl
    import food_spawn_ctrl_pkg::*;
#(
    parameter int unsigned MAX_TRIES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_spawn_req,
    input  logic [7:0]          i_rnd_in,
    output logic                o_rnd_step,
    output logic                o_occ_rd,
    output logic [COL_BITS-1:0] o_occ_x,
    output logic [ROW_BITS-1:0] o_occ_y,
    input  logic                i_occ_hit,
    output logic [COL_BITS-1:0] o_food_x,
    output logic [ROW_BITS-1:0] o_food_y,
    output logic                o_busy,
    output logic                o_spawn_done,
    output logic                o_spawn_fail
);

    localparam int unsigned TRY_BITS = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    state_e              r_state;
    state_e              w_state_d;
    logic [TRY_BITS-1:0] r_tries;
    cell_t               r_cand;
    cell_t               r_occ;
    cell_t               r_food;

    logic [COL_BITS-1:0] w_rnd_x;
    logic [ROW_BITS-1:0] w_rnd_y;
    logic                w_x_ok;
    logic                w_y_ok;
    logic                w_last_try;
    logic                w_scan_load;
    logic                w_scan_adv;
    logic                w_scan_all;
    cell_t               w_scan_pos;
    cell_t               w_scan_next;

    assign w_rnd_x    = i_rnd_in[COL_BITS-1:0];
    assign w_rnd_y    = i_rnd_in[7 -: ROW_BITS];
    assign w_x_ok     = (32'(w_rnd_x) < GRID_W);
    assign w_y_ok     = (32'(w_rnd_y) < GRID_H);
    assign w_last_try = (32'(r_tries) == MAX_TRIES - 1);

    assign w_scan_load = (r_state == StReject) && w_last_try;
    assign w_scan_adv  = (r_state == StScanWt) && i_occ_hit && !w_scan_all;

    food_spawn_ctrl_grid_scan_ctr u_scan (
        .clk           (clk),
        .rst           (rst),
        .i_load        (w_scan_load),
        .i_from        (r_cand),
        .i_adv         (w_scan_adv),
        .i_count       (r_state == StScanRd),
        .o_pos         (w_scan_pos),
        .o_pos_next    (w_scan_next),
        .o_all_scanned (w_scan_all)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:   if (i_spawn_req) w_state_d = StDrawX;
            StDrawX:  w_state_d = w_x_ok ? StDrawY : StReject;
            StDrawY:  w_state_d = w_y_ok ? StCheck : StReject;
            StCheck:  w_state_d = StWait;
            StWait:   w_state_d = i_occ_hit ? StReject : StDone;
            StReject: w_state_d = w_last_try ? StScanRd : StDrawX;
            StScanRd: w_state_d = StScanWt;
            StScanWt: begin
                if (!i_occ_hit)     w_state_d = StDone;
                else if (w_scan_all) w_state_d = StFail;
                else                 w_state_d = StScanRd;
            end
            StDone:   w_state_d = StIdle;
            StFail:   w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Datapath: try count, candidate, query address (loaded on entry to a read state), food.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tries <= '0;
            r_cand  <= '0;
            r_occ   <= '0;
            r_food  <= '0;
        end else begin
            if (r_state == StIdle && i_spawn_req) begin
                r_tries <= '0;
            end
            if (r_state == StReject && !w_last_try) begin
                r_tries <= r_tries + 1'b1;
            end
            if (r_state == StDrawX && w_x_ok) begin
                r_cand.x <= w_rnd_x;
            end
            if (r_state == StDrawY && w_y_ok) begin
                r_cand.y <= w_rnd_y;
                r_occ    <= '{x: r_cand.x, y: w_rnd_y};
            end
            if (w_scan_load) begin
                r_occ <= next_cell(r_cand);
            end
            if (w_scan_adv) begin
                r_occ <= w_scan_next;
            end
            // Food is written on entry to DONE so it is already valid during the done pulse.
            if (r_state == StWait && !i_occ_hit) begin
                r_food <= r_cand;
            end
            if (r_state == StScanWt && !i_occ_hit) begin
                r_cand <= w_scan_pos;
                r_food <= w_scan_pos;
            end
        end
    end

    assign o_rnd_step   = (r_state == StDrawX) || (r_state == StDrawY);
    assign o_occ_rd     = (r_state == StCheck) || (r_state == StScanRd);
    assign o_occ_x      = r_occ.x;
    assign o_occ_y      = r_occ.y;
    assign o_food_x     = r_food.x;
    assign o_food_y     = r_food.y;
    assign o_busy       = (r_state != StIdle);
    assign o_spawn_done = (r_state == StDone);
    assign o_spawn_fail = (r_state == StFail);

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Directed bench for food_spawn_ctrl with an LFSR-value sequencer and occupancy-map responder.
module tb_food_spawn_ctrl;
    import food_spawn_ctrl_pkg::*;

    logic                clk;
    logic                rst;
    logic                spawn_req;
    logic [7:0]          rnd_in;
    logic                rnd_step;
    logic                occ_rd;
    logic [COL_BITS-1:0] occ_x;
    logic [ROW_BITS-1:0] occ_y;
    logic                occ_hit;
    logic [COL_BITS-1:0] food_x;
    logic [ROW_BITS-1:0] food_y;
    logic                busy;
    logic                spawn_done;
    logic                spawn_fail;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rnd_seq [0:63];
    bit         occ_map [0:NUM_CELLS-1];
    int step_cnt = 0;
    int rd_cnt   = 0;
    int done_cnt = 0;
    int fail_cnt = 0;
    int step_base = 0;

    food_spawn_ctrl #(.MAX_TRIES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_spawn_req  (spawn_req),
        .i_rnd_in     (rnd_in),
        .o_rnd_step   (rnd_step),
        .o_occ_rd     (occ_rd),
        .o_occ_x      (occ_x),
        .o_occ_y      (occ_y),
        .i_occ_hit    (occ_hit),
        .o_food_x     (food_x),
        .o_food_y     (food_y),
        .o_busy       (busy),
        .o_spawn_done (spawn_done),
        .o_spawn_fail (spawn_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LFSR stand-in: rnd_in moves to the next table entry after each rnd_step edge.
    assign rnd_in = rnd_seq[(step_cnt - step_base) & 63];

    // Event counters and occupancy responder (hit valid one cycle after occ_rd).
    always @(posedge clk) begin
        if (rnd_step)   step_cnt <= step_cnt + 1;
        if (occ_rd)     rd_cnt   <= rd_cnt + 1;
        if (spawn_done) done_cnt <= done_cnt + 1;
        if (spawn_fail) fail_cnt <= fail_cnt + 1;
        if (occ_rd && (int'(occ_y) < GRID_H))
            occ_hit <= occ_map[int'(occ_y) * GRID_W + int'(occ_x)];
        else
            occ_hit <= 1'b0;
    end

    task automatic fill_occ(input bit v);
        for (int i = 0; i < NUM_CELLS; i++) occ_map[i] = v;
    endtask

    task automatic fill_pairs(input logic [7:0] bx, input logic [7:0] by);
        for (int i = 0; i < 64; i += 2) begin
            rnd_seq[i]   = bx;
            rnd_seq[i+1] = by;
        end
    endtask

    // Issue one request from IDLE; returns cycles from request cycle to done/fail pulse.
    task automatic run_req(input int budget, output int lat, output bit got_done,
                           output bit got_fail);
        lat = 0;
        got_done = 1'b0;
        got_fail = 1'b0;
        step_base = step_cnt;
        @(negedge clk);
        spawn_req = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            spawn_req = 1'b0;
            if (spawn_done || spawn_fail) begin
                lat = c;
                got_done = spawn_done;
                got_fail = spawn_fail;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        spawn_req = 1'b0;
        fill_pairs(8'h00, 8'h00);
        fill_occ(1'b0);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rnd_step, occ_rd, busy, spawn_done, spawn_fail} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {rnd_step, occ_rd, busy, spawn_done, spawn_fail});
        end
        n_checks++;
        if ({occ_x, occ_y, food_x, food_y} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_coords: got %h expected 0", {occ_x, occ_y, food_x, food_y});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rnd_step !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_step: busy=%b step=%b expected 0 0", busy, rnd_step);
        end
    endtask

    task automatic test_free_board();
        int lat; bit d; bit f; int s0; int r0;
        fill_occ(1'b0);
        rnd_seq[0] = 8'h2B;
        rnd_seq[1] = 8'h51;
        s0 = step_cnt; r0 = rd_cnt;
        run_req(50, lat, d, f);
        n_checks++;
        if (!d || lat != 5) begin
            n_fail++;
            $display("FAIL free_latency: done=%b lat=%0d expected done=1 lat=5", d, lat);
        end
        n_checks++;
        if (food_x !== 5'd11 || food_y !== 5'd10) begin
            n_fail++;
            $display("FAIL free_food: got (%0d,%0d) expected (11,10)", food_x, food_y);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_done: got %b expected 1", busy);
        end
        @(negedge clk);
        n_checks++;
        if (spawn_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b busy=%b expected 0 0", spawn_done, busy);
        end
        n_checks++;
        if (step_cnt - s0 != 2 || rd_cnt - r0 != 1) begin
            n_fail++;
            $display("FAIL free_counts: steps=%0d reads=%0d expected 2 1",
                     step_cnt - s0, rd_cnt - r0);
        end
    endtask

    task automatic test_busy_req();
        int d0; int s0;
        fill_occ(1'b0);
        rnd_seq[0] = 8'h04;
        rnd_seq[1] = 8'h10;
        d0 = done_cnt; s0 = step_cnt;
        step_base = step_cnt;
        @(negedge clk);
        spawn_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            spawn_req = (c == 2) || (c == 5);
            if (c >= 6) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_req_dropped: cycle %0d busy=%b expected 0", c, busy);
                end
            end
        end
        spawn_req = 1'b0;
        n_checks++;
        if (done_cnt - d0 != 1 || step_cnt - s0 != 2) begin
            n_fail++;
            $display("FAIL busy_req_counts: dones=%0d steps=%0d expected 1 2",
                     done_cnt - d0, step_cnt - s0);
        end
        n_checks++;
        if (food_x !== 5'd4 || food_y !== 5'd2) begin
            n_fail++;
            $display("FAIL busy_req_food: got (%0d,%0d) expected (4,2)", food_x, food_y);
        end
    endtask

    task automatic test_row_range();
        int lat; bit d; bit f; int s0;
        fill_occ(1'b0);
        rnd_seq[0] = 8'h07;
        rnd_seq[1] = 8'hD8;   // y = 27, out of range
        rnd_seq[2] = 8'h0C;
        rnd_seq[3] = 8'h28;   // y = 5
        s0 = step_cnt;
        run_req(50, lat, d, f);
        n_checks++;
        if (!d || lat != 8) begin
            n_fail++;
            $display("FAIL range_latency: done=%b lat=%0d expected done=1 lat=8", d, lat);
        end
        n_checks++;
        if (food_x !== 5'd12 || food_y !== 5'd5) begin
            n_fail++;
            $display("FAIL range_food: got (%0d,%0d) expected (12,5)", food_x, food_y);
        end
        n_checks++;
        if (step_cnt - s0 != 4) begin
            n_fail++;
            $display("FAIL range_steps: got %0d expected 4", step_cnt - s0);
        end
        @(negedge clk);
    endtask

    task automatic test_occupied();
        int lat; bit d; bit f; int r0;
        fill_occ(1'b0);
        occ_map[4 * GRID_W + 3] = 1'b1;
        rnd_seq[0] = 8'h03;
        rnd_seq[1] = 8'h20;   // (3,4) occupied
        rnd_seq[2] = 8'h03;
        rnd_seq[3] = 8'h38;   // (3,7) free
        r0 = rd_cnt;
        run_req(50, lat, d, f);
        n_checks++;
        if (!d || lat != 10) begin
            n_fail++;
            $display("FAIL occ_latency: done=%b lat=%0d expected done=1 lat=10", d, lat);
        end
        n_checks++;
        if (food_x !== 5'd3 || food_y !== 5'd7 || rd_cnt - r0 != 2) begin
            n_fail++;
            $display("FAIL occ_food: got (%0d,%0d) reads=%0d expected (3,7) reads=2",
                     food_x, food_y, rd_cnt - r0);
        end
        @(negedge clk);
    endtask

    task automatic test_full_fail();
        int lat; bit d; bit f; int r0; int s0;
        fill_occ(1'b1);
        fill_pairs(8'h05, 8'h28);
        r0 = rd_cnt; s0 = step_cnt;
        run_req(3000, lat, d, f);
        n_checks++;
        if (!f || d || lat != 1617) begin
            n_fail++;
            $display("FAIL full_fail: fail=%b done=%b lat=%0d expected 1 0 1617", f, d, lat);
        end
        n_checks++;
        if (rd_cnt - r0 != 16 + NUM_CELLS || step_cnt - s0 != 32) begin
            n_fail++;
            $display("FAIL full_counts: reads=%0d steps=%0d expected %0d 32",
                     rd_cnt - r0, step_cnt - s0, 16 + NUM_CELLS);
        end
        n_checks++;
        if (food_x !== 5'd3 || food_y !== 5'd7) begin
            n_fail++;
            $display("FAIL full_food_kept: got (%0d,%0d) expected (3,7)", food_x, food_y);
        end
        @(negedge clk);
        n_checks++;
        if (spawn_fail !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fail_pulse: fail=%b busy=%b expected 0 0", spawn_fail, busy);
        end
    endtask

    task automatic test_scan_wrap();
        int lat; bit d; bit f; int r0; int s0;
        fill_occ(1'b1);
        occ_map[0] = 1'b0;
        fill_pairs(8'h05, 8'h28);
        rnd_seq[30] = 8'h1E;  // last draw (30,23): scan starts at (31,23)
        rnd_seq[31] = 8'hB8;
        r0 = rd_cnt; s0 = step_cnt;
        run_req(500, lat, d, f);
        n_checks++;
        if (!d || lat != 85) begin
            n_fail++;
            $display("FAIL wrap_latency: done=%b lat=%0d expected done=1 lat=85", d, lat);
        end
        n_checks++;
        if (food_x !== 5'd0 || food_y !== 5'd0) begin
            n_fail++;
            $display("FAIL wrap_food: got (%0d,%0d) expected (0,0)", food_x, food_y);
        end
        n_checks++;
        if (rd_cnt - r0 != 18 || step_cnt - s0 != 32) begin
            n_fail++;
            $display("FAIL wrap_counts: reads=%0d steps=%0d expected 18 32",
                     rd_cnt - r0, step_cnt - s0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        int r0; int f0; int d0; bit in_scan;
        fill_occ(1'b1);
        fill_pairs(8'h05, 8'h28);
        r0 = rd_cnt; f0 = fail_cnt; d0 = done_cnt;
        in_scan = 1'b0;
        step_base = step_cnt;
        @(negedge clk);
        spawn_req = 1'b1;
        for (int c = 1; c <= 500; c++) begin
            @(negedge clk);
            spawn_req = (c % 7 == 0);   // stray requests while busy
            if (rd_cnt - r0 >= 24) begin
                in_scan = 1'b1;
                break;
            end
        end
        spawn_req = 1'b0;
        n_checks++;
        if (!in_scan || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_scan_reached: reached=%b busy=%b expected 1 1", in_scan, busy);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({rnd_step, occ_rd, busy, spawn_done, spawn_fail} !== 5'b0 ||
            {occ_x, occ_y, food_x, food_y} !== 20'h0) begin
            n_fail++;
            $display("FAIL mid_scan_reset: ctrl=%b coords=%h expected 00000 0",
                     {rnd_step, occ_rd, busy, spawn_done, spawn_fail},
                     {occ_x, occ_y, food_x, food_y});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || fail_cnt != f0 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b fails=%0d dones=%0d expected 0 0 0",
                     busy, fail_cnt - f0, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_free_board();
        test_busy_req();
        test_row_range();
        test_occupied();
        test_full_fail();
        test_scan_wrap();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
